// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU controller:
// operation codes and controller state encoding.
package serial_alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND, OR, or full-adder sum.
// Ports: a, b, cin (bit inputs), op (00 AND, 01 OR, 1x sum),
// cout (adder carry, 0 for AND/OR), result (slice output bit).
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       cout,
    output logic       result
);

    always_comb begin
        result = 1'b0;
        cout   = 1'b0;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: begin
                result = a ^ b ^ cin;
                cout   = (a & b) | (cin & (a ^ b));
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial execute unit: feeds one operand bit per cycle (LSB
// first) through alu_bit_slice, holding the carry in a register.
// Ports: clk, reset (async, active-high); start_valid/start_ready
// request handshake with a, b, op; result/carry_out/result_valid
// with result_ready; busy while running.
// Optional SERIAL_ALU_FLAGS_EN adds zero_flag and overflow_flag.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             carry_out,
`ifdef SERIAL_ALU_FLAGS_EN
    output logic             zero_flag,
    output logic             overflow_flag,
`endif
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             s_b;
    logic [1:0]       s_op;
    logic             s_cout;
    logic             s_res;
    logic             accept;
    logic             last;
    logic             arith;

    assign accept = (state == S_IDLE) && start_valid;
    assign last   = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign arith  = op_q[1];

    // SUB is a + ~b + 1: invert b here, the +1 is the preset carry.
    assign s_b  = b_sh[0] ^ (op_q == OP_SUB);
    assign s_op = arith ? OP_ADD : op_q;

    alu_bit_slice u_slice (
        .a      (a_sh[0]),
        .b      (s_b),
        .cin    (carry_q),
        .op     (s_op),
        .cout   (s_cout),
        .result (s_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start_valid) state_nxt = S_RUN;
            S_RUN:  if (last) state_nxt = S_DONE;
            S_DONE: if (result_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == S_IDLE);
        busy         = (state == S_RUN);
        result_valid = (state == S_DONE);
    end

    // result/carry_out are loaded on the final RUN cycle so they stay
    // put through DONE and the following IDLE/RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= OP_AND;
            carry_q   <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            op_q    <= op;
            cnt     <= '0;
            carry_q <= (op == OP_SUB);
        end else if (state == S_RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= {s_res, res_sh[WIDTH-1:1]};
            carry_q <= s_cout;
            cnt     <= cnt + CNT_W'(1);
            if (last) begin
                result    <= {s_res, res_sh[WIDTH-1:1]};
                carry_out <= arith & s_cout;
            end
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic zero_q;

    // zero_q is sticky: any 1 result bit clears it for the operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q        <= 1'b0;
            zero_flag     <= 1'b0;
            overflow_flag <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b1;
        end else if (state == S_RUN) begin
            zero_q <= zero_q & ~s_res;
            if (last) begin
                zero_flag     <= zero_q & ~s_res;
                overflow_flag <= arith & (carry_q ^ s_cout);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: behavioural model plus
// directed literal cases and randomized operations.
module tb_serial_alu_ctrl;

`ifdef SERIAL_ALU_FLAGS_EN
    localparam int W = 8;
`else
    localparam int W = 32;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic         carry_out;
    logic         busy;
`ifdef SERIAL_ALU_FLAGS_EN
    logic         zero_flag;
    logic         overflow_flag;
`endif

    int checks = 0;
    int errors = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .op           (op),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .carry_out    (carry_out),
`ifdef SERIAL_ALU_FLAGS_EN
        .zero_flag    (zero_flag),
        .overflow_flag(overflow_flag),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [W-1:0] f_res(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x + y;
            default: return x - y;
        endcase
    endfunction

    function automatic logic f_cy(input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  input logic [1:0] o);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        case (o)
            2'b10:   return s[W];
            2'b11:   return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_ov(input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  input logic [1:0] o);
        logic [W-1:0] r;
        r = f_res(x, y, o);
        case (o)
            2'b10:   return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            2'b11:   return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            default: return 1'b0;
        endcase
    endfunction

    // Model: phase flags, cycles remaining, last accepted operands.
    bit           m_idle = 1'b1;
    bit           m_run = 1'b0;
    bit           m_done = 1'b0;
    bit           m_have = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [1:0]   m_op = 2'b00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idle <= 1'b1;
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_have <= 1'b0;
        end else if (m_idle) begin
            if (start_valid) begin
                m_a    <= a;
                m_b    <= b;
                m_op   <= op;
                m_left <= W;
                m_idle <= 1'b0;
                m_run  <= 1'b1;
            end
        end else if (m_run) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
                m_have <= 1'b1;
            end
        end else if (m_done && result_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    logic [W-1:0] e_res;
    logic         e_cy;

    always @(negedge clk) begin
        e_res = m_have ? f_res(m_a, m_b, m_op) : '0;
        e_cy  = m_have ? f_cy(m_a, m_b, m_op) : 1'b0;
        chk("start_ready", 64'(start_ready), 64'(m_idle));
        chk("busy", 64'(busy), 64'(m_run));
        chk("result_valid", 64'(result_valid), 64'(m_done));
        if (!m_run) begin
            chk("result", 64'(result), 64'(e_res));
            chk("carry_out", 64'(carry_out), 64'(e_cy));
`ifdef SERIAL_ALU_FLAGS_EN
            chk("zero_flag", 64'(zero_flag),
                64'(m_have && (e_res == '0)));
            chk("overflow_flag", 64'(overflow_flag),
                64'(m_have && f_ov(m_a, m_b, m_op)));
`endif
        end
    end

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [1:0] o, input int hold,
                          input bit noise, output logic [W-1:0] r,
                          output logic c, output int lat);
        int n;
        n = 0;
        while (!start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 64'(0), 64'(1));
        a = x;
        b = y;
        op = o;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        while (!result_valid && lat < 200) begin
            if (noise) start_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        start_valid = 1'b0;
        if (lat >= 200) chk("valid_timeout", 64'(0), 64'(1));
        r = result;
        c = carry_out;
        repeat (hold) begin
            if (noise) start_valid = 1'($urandom);
            @(negedge clk);
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    logic [W-1:0] r;
    logic         c;
    int           lat;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 64'(1));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_valid", 64'(result_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        @(negedge clk);

`ifndef SERIAL_ALU_FLAGS_EN
        run_op(32'hFFFF_FFFF, 32'h1, 2'b10, 0, 1'b0, r, c, lat);
        chk("add_ovf_res", 64'(r), 64'h0);
        chk("add_ovf_cy", 64'(c), 64'(1));
        chk("add_latency", 64'(lat), 64'(32));
        run_op(32'd5, 32'd7, 2'b11, 0, 1'b0, r, c, lat);
        chk("sub_neg_res", 64'(r), 64'hFFFF_FFFE);
        chk("sub_neg_cy", 64'(c), 64'(0));
        run_op(32'd7, 32'd5, 2'b11, 1, 1'b0, r, c, lat);
        chk("sub_pos_res", 64'(r), 64'h2);
        chk("sub_pos_cy", 64'(c), 64'(1));
        run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b00, 0, 1'b0, r, c, lat);
        chk("and_res", 64'(r), 64'h00F0_1234);
        chk("and_cy", 64'(c), 64'(0));
        run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b01, 0, 1'b0, r, c, lat);
        chk("or_res", 64'(r), 64'hFFF0_FFFF);
        chk("or_cy", 64'(c), 64'(0));
        run_op(32'd100, 32'd23, 2'b10, 5, 1'b1, r, c, lat);
        chk("bp_res", 64'(r), 64'd123);
        chk("bp_stable", 64'(result), 64'd123);
`else
        run_op(8'h7F, 8'h01, 2'b10, 0, 1'b0, r, c, lat);
        chk("f_add_res", 64'(r), 64'h80);
        chk("f_add_ov", 64'(overflow_flag), 64'(1));
        chk("f_add_z", 64'(zero_flag), 64'(0));
        run_op(8'h10, 8'h10, 2'b11, 0, 1'b0, r, c, lat);
        chk("f_sub_res", 64'(r), 64'h0);
        chk("f_sub_z", 64'(zero_flag), 64'(1));
        chk("f_sub_cy", 64'(c), 64'(1));
`endif

        // Asynchronous reset in the middle of an ADD.
        a = W'(5);
        b = W'(9);
        op = 2'b10;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (W / 2 - 1) @(negedge clk);
        #2;
        chk("busy_pre_rst", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ready", 64'(start_ready), 64'(1));
        chk("mid_rst_valid", 64'(result_valid), 64'(0));
        chk("mid_rst_result", 64'(result), 64'(0));
        chk("mid_rst_cy", 64'(carry_out), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(W'(3), W'(4), 2'b10, 0, 1'b0, r, c, lat);
        chk("post_rst_add", 64'(r), 64'd7);

        for (int i = 0; i < 60; i++) begin
            run_op(W'($urandom), W'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), r, c, lat);
            chk("rnd_latency", 64'(lat), 64'(W));
            result_ready = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            result_ready = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
